// File: rtl/bj_issue_sched.sv
// -----------------------------------------------------------------------------
// bj_issue_sched
//
// In-order issue scheduler for the single branch/jump unit (BJU). Two dispatch
// lanes (lane 0 older than lane 1) enqueue into a small circular queue, and the
// head is issued to the BJU one op per cycle. The BJU always accepts, so an
// issue pops the head in the same cycle. A BJU flush discards every younger
// buffered op and parks the block in RECOVER for RECOVER_CYCLES cycles. A
// pipeline-wide ext_flush empties the queue and returns straight to RUN.
//
// Ports:
//   clk, reset_n        core clock, asynchronous active-low reset
//   in0_valid/payload   lane 0 (older) dispatch op
//   in1_valid/payload   lane 1 (younger) dispatch op
//   in_ready            both lanes accepted this cycle (all-or-nothing)
//   bju_valid/payload   op issued to the BJU (head of queue, 0 when idle)
//   bju_flush           BJU flush for the op issued this cycle
//   ext_flush           pipeline-wide flush, highest priority
//   count               occupied queue entries
//   mispredict_cnt      saturating count of honoured BJU flushes
// -----------------------------------------------------------------------------
module bj_issue_sched #(
  parameter int PAYLOAD_W      = 128,
  parameter int DEPTH          = 4,  // power of 2, >= 2
  parameter int RECOVER_CYCLES = 2   // >= 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in0_valid,
  input  logic [PAYLOAD_W-1:0]         in0_payload,
  input  logic                         in1_valid,
  input  logic [PAYLOAD_W-1:0]         in1_payload,
  output logic                         in_ready,
  output logic                         bju_valid,
  output logic [PAYLOAD_W-1:0]         bju_payload,
  input  logic                         bju_flush,
  input  logic                         ext_flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Keep the recovery counter at least one bit wide when RECOVER_CYCLES == 1.
  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [RW-1:0]        rec_q, rec_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [31:0]          mis_q, mis_d;

  logic [PAYLOAD_W-1:0] mem [DEPTH];

  logic                 run;
  logic                 mispredict;
  logic                 enq_ok;
  logic                 wr0;
  logic                 wr1;
  logic [AW-1:0]        wr1_addr;
  logic [1:0]           n_enq;

  // ---------------------------------------------------------------------------
  // Handshake and issue: driven from registers only, so there is no
  // combinational path from any input to in_ready or bju_valid.
  // ---------------------------------------------------------------------------
  assign run         = (state_q == RUN);
  // Two free slots are needed because acceptance is all-or-nothing for both lanes.
  assign in_ready    = run && (count_q <= CW'(DEPTH - 2));
  assign bju_valid   = run && (count_q != '0);
  assign bju_payload = bju_valid ? mem[rptr_q] : '0;

  // A BJU flush only counts when an op was actually issued and no external
  // flush overrides it.
  assign mispredict  = bju_valid && bju_flush && !ext_flush;

  // Any flush drops the same-cycle enqueue; dispatch is flushed alongside.
  assign enq_ok      = in_ready && !ext_flush && !mispredict;
  assign wr0         = enq_ok && in0_valid;
  assign wr1         = enq_ok && in1_valid;
  // Lane 1 packs directly behind lane 0, or takes wptr when lane 0 is empty.
  assign wr1_addr    = wptr_q + AW'(in0_valid);
  assign n_enq       = {1'b0, wr0} + {1'b0, wr1};

  assign count          = count_q;
  assign mispredict_cnt = mis_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d = state_q;
    rec_d   = rec_q;
    rptr_d  = rptr_q + AW'(bju_valid);
    wptr_d  = wptr_q + AW'(n_enq);
    count_d = count_q + CW'(n_enq) - CW'(bju_valid);
    mis_d   = mis_q;

    if (ext_flush) begin
      state_d = RUN;
      rec_d   = '0;
      rptr_d  = wptr_q;
      wptr_d  = wptr_q;
      count_d = '0;
    end else if (mispredict) begin
      state_d = RECOVER;
      rec_d   = RW'(RECOVER_CYCLES - 1);
      rptr_d  = wptr_q;
      wptr_d  = wptr_q;
      count_d = '0;
      if (mis_q != 32'hFFFF_FFFF) mis_d = mis_q + 32'd1;
    end else if (state_q == RECOVER) begin
      // The counter is loaded with RECOVER_CYCLES-1, so leaving on zero gives
      // exactly RECOVER_CYCLES cycles in RECOVER.
      if (rec_q == '0) state_d = RUN;
      else             rec_d   = rec_q - RW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q <= RUN;
      rec_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end

  // NOTE: the payload storage is deliberately not reset; an entry is only read
  // when count marks it occupied, and bju_payload is forced to 0 otherwise.
  always_ff @(posedge clk) begin
    if (wr0) mem[wptr_q]   <= in0_payload;
    if (wr1) mem[wr1_addr] <= in1_payload;
  end

endmodule

// File: tb/tb_bj_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_bj_issue_sched
//
// Bench for bj_issue_sched. A driver applies directed and random stimulus on
// the falling edge, predicts the block's visible outputs for each cycle from a
// queue-level reference model and pushes the prediction into a scoreboard. A
// separate monitor pops one prediction per cycle shortly after the falling
// edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_bj_issue_sched;

  localparam int PW    = 128;
  localparam int DEPTH = 4;
  localparam int RC    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk;
  logic           clk_en;
  logic           reset_n;
  logic           in0_valid;
  logic [PW-1:0]  in0_payload;
  logic           in1_valid;
  logic [PW-1:0]  in1_payload;
  logic           in_ready;
  logic           bju_valid;
  logic [PW-1:0]  bju_payload;
  logic           bju_flush;
  logic           ext_flush;
  logic [CW-1:0]  count;
  logic [31:0]    mispredict_cnt;

  bj_issue_sched #(
    .PAYLOAD_W      (PW),
    .DEPTH          (DEPTH),
    .RECOVER_CYCLES (RC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in0_valid      (in0_valid),
    .in0_payload    (in0_payload),
    .in1_valid      (in1_valid),
    .in1_payload    (in1_payload),
    .in_ready       (in_ready),
    .bju_valid      (bju_valid),
    .bju_payload    (bju_payload),
    .bju_flush      (bju_flush),
    .ext_flush      (ext_flush),
    .count          (count),
    .mispredict_cnt (mispredict_cnt)
  );

  // Gated clock so the async-reset test can stop it.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the queue contents as an ordered list, plus the number of
  // blocked cycles still owed after a BJU flush.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] mq[$];
  int            rec_left;
  logic [31:0]   mcnt;

  function automatic logic m_ready();
    return (rec_left == 0) && ((DEPTH - mq.size()) >= 2);
  endfunction

  function automatic logic m_valid();
    return (rec_left == 0) && (mq.size() != 0);
  endfunction

  typedef struct {
    logic          ready;
    logic          valid;
    logic [PW-1:0] payload;
    int            cnt;
    logic [31:0]   mcnt;
  } exp_t;

  exp_t exp_q[$];

  // One cycle: predict outputs, drive inputs, then advance the model across
  // the coming rising edge.
  task automatic step(input logic v0, input logic [PW-1:0] p0,
                      input logic v1, input logic [PW-1:0] p1,
                      input logic bf, input logic ef);
    exp_t e;
    logic rdy;
    logic vld;
    @(negedge clk);
    rdy       = m_ready();
    vld       = m_valid();
    e.ready   = rdy;
    e.valid   = vld;
    e.payload = vld ? mq[0] : '0;
    e.cnt     = mq.size();
    e.mcnt    = mcnt;
    exp_q.push_back(e);

    in0_valid   = v0;
    in0_payload = p0;
    in1_valid   = v1;
    in1_payload = p1;
    bju_flush   = bf;
    ext_flush   = ef;

    if (ef) begin
      mq.delete();
      rec_left = 0;
    end else if (bf && vld) begin
      mq.delete();
      rec_left = RC;
      if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
    end else if (rec_left > 0) begin
      rec_left = rec_left - 1;
    end else begin
      if (vld) void'(mq.pop_front());
      if (rdy) begin
        if (v0) mq.push_back(p0);
        if (v1) mq.push_back(p1);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0);
  endtask

  function automatic logic [PW-1:0] rnd_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares one scoreboard entry per cycle, away from the rising edge.
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("in_ready",       PW'(in_ready),       PW'(e.ready));
        check("bju_valid",      PW'(bju_valid),      PW'(e.valid));
        check("bju_payload",    bju_payload,         e.payload);
        check("count",          PW'(count),          PW'(e.cnt));
        check("mispredict_cnt", PW'(mispredict_cnt), PW'(e.mcnt));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic          acc;

    clk_en      = 1'b1;
    reset_n     = 1'b0;
    in0_valid   = 1'b0;
    in0_payload = '0;
    in1_valid   = 1'b0;
    in1_payload = '0;
    bju_flush   = 1'b0;
    ext_flush   = 1'b0;
    rec_left    = 0;
    mcnt        = '0;

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    check("rst in_ready",    PW'(in_ready),       PW'(1));
    check("rst bju_valid",   PW'(bju_valid),      PW'(0));
    check("rst bju_payload", bju_payload,         '0);
    check("rst count",       PW'(count),          PW'(0));
    check("rst mispredict",  PW'(mispredict_cnt), PW'(0));
    reset_n = 1'b1;

    // Single op.
    step(1, PW'(32'hA), 0, '0, 0, 0);
    idle(2);

    // Ordering across lanes and cycles.
    step(1, PW'(32'h1), 1, PW'(32'h2), 0, 0);
    step(0, '0,         1, PW'(32'h3), 0, 0);
    idle(4);

    // Backpressure: hold each pair until accepted.
    for (int i = 0; i < 10; i++) begin
      pa = PW'(32'h100 + 2 * i);
      pb = PW'(32'h101 + 2 * i);
      do begin
        acc = m_ready();
        step(1, pa, 1, pb, 0, 0);
      end while (!acc);
    end
    idle(6);

    // BJU flush drops younger entries and the same-cycle enqueue of 0x9.
    step(1, PW'(32'h1), 1, PW'(32'h2), 0, 0);
    step(0, '0,         1, PW'(32'h3), 0, 0);
    step(1, PW'(32'h9), 0, '0,         1, 0);
    idle(4);

    // ext_flush during RECOVER returns to RUN immediately.
    step(1, PW'(32'h5), 1, PW'(32'h6), 0, 0);
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 0, 1);
    idle(2);

    // Simultaneous ext_flush and bju_flush on a valid issue: not counted.
    step(1, PW'(32'h7), 0, '0, 0, 0);
    step(1, PW'(32'hE), 1, PW'(32'hF), 1, 1);
    idle(2);

    // ext_flush in RUN with a non-empty queue.
    step(1, PW'(32'h8), 1, PW'(32'h9), 0, 0);
    step(1, PW'(32'hA), 1, PW'(32'hB), 0, 1);
    idle(2);

    // bju_flush with nothing issued is ignored.
    step(0, '0, 0, '0, 1, 0);
    idle(1);

    // Async reset mid-RECOVER with the clock stopped.
    step(1, PW'(32'h11), 1, PW'(32'h12), 0, 0);
    step(0, '0, 0, '0, 1, 0);
    idle(1);
    #2;
    clk_en = 1'b0;
    #10;
    reset_n = 1'b0;
    #1;
    check("async count",     PW'(count),          PW'(0));
    check("async bju_valid", PW'(bju_valid),      PW'(0));
    check("async in_ready",  PW'(in_ready),       PW'(1));
    check("async mispred",   PW'(mispredict_cnt), PW'(0));
    mq.delete();
    rec_left = 0;
    mcnt     = '0;
    #4;
    reset_n = 1'b1;
    #1;
    check("post-rst in_ready", PW'(in_ready), PW'(1));
    clk_en = 1'b1;
    idle(2);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), rnd_payload(),
           1'($urandom_range(0, 1)), rnd_payload(),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 31) == 0));
    end
    idle(8);

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
